nf_lsu: RTL and testbench

Load/store unit for the nanoFOX execute stage. Consumes the ALU result as the effective address, sequences one data-memory transaction per load/store over a request/acknowledge bus, and stalls the pipeline until the transaction completes. It handles byte-lane placement and byte enables for stores, and lane extraction with sign/zero extension for loads. It flags misaligned accesses without issuing a bus access.

---
 rtl/nf_lsu_pkg.sv | 9 +
 rtl/nf_lsu_align.sv | 48 ++++
 rtl/nf_lsu.sv | 158 +++++++++++++++
 tb/tb_nf_lsu.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/nf_lsu_pkg.sv
// Shared definitions for the nanoFOX load/store unit.
// The access-size encodings are the same ones the decoder emits.
package nf_lsu_pkg;

  localparam logic [1:0] LSU_BYTE = 2'b00;
  localparam logic [1:0] LSU_HALF = 2'b01;
  localparam logic [1:0] LSU_WORD = 2'b10;

endpackage

// File: rtl/nf_lsu_align.sv
// Combinational lane logic: store replication and byte enables, misalign check,
// and load lane extraction with sign/zero extension.
module nf_lsu_align
  import nf_lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        sign_ext_i,
  input  logic [31:0] wd_i,
  input  logic [31:0] rd_i,
  output logic [31:0] wd_rep_o,
  output logic [3:0]  be_o,
  output logic        misalign_o,
  output logic [31:0] rd_ext_o
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    wd_rep_o   = wd_i;
    be_o       = 4'b1111;
    misalign_o = 1'b0;
    rd_ext_o   = rd_i;
    rd_byte    = rd_i[{addr_lo_i, 3'b000} +: 8];
    rd_half    = rd_i[{addr_lo_i[1], 4'b0000} +: 16];
    case (size_i)
      LSU_BYTE: begin
        wd_rep_o = {4{wd_i[7:0]}};
        be_o     = 4'b0001 << addr_lo_i;
        rd_ext_o = {{24{sign_ext_i & rd_byte[7]}}, rd_byte};
      end
      LSU_HALF: begin
        wd_rep_o   = {2{wd_i[15:0]}};
        be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        misalign_o = addr_lo_i[0];
        rd_ext_o   = {{16{sign_ext_i & rd_half[15]}}, rd_half};
      end
      LSU_WORD: begin
        misalign_o = |addr_lo_i;
      end
      default: begin
        misalign_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/nf_lsu.sv
// Load/store unit: one request/ack bus transaction per load/store, stalling the
// pipeline until it completes. Misaligned accesses retire without touching the bus.
//
// state  | meaning
// IDLE   | no access pending; accepts req_i
// REQ    | req_dm asserted, bus outputs held until ack_dm
// WAIT_R | load acknowledged, waiting for rvalid_dm
// DONE   | one-cycle retire pulse, pipeline released
module nf_lsu
  import nf_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        sign_ext_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wd_i,
  output logic        stall_o,
  output logic        done_o,
  output logic        misalign_o,
  output logic [31:0] rd_data_o,
  output logic [31:0] addr_dm,
  output logic [31:0] wd_dm,
  output logic [3:0]  be_dm,
  output logic        we_dm,
  output logic        req_dm,
  input  logic        ack_dm,
  input  logic        rvalid_dm,
  input  logic [31:0] rd_dm
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic        we_q, we_d;
  logic        misalign_q, misalign_d;
  logic [31:0] rd_data_q, rd_data_d;

  logic        idle;
  logic [1:0]  al_size;
  logic [1:0]  al_lo;
  logic [31:0] al_wd_rep;
  logic [3:0]  al_be;
  logic        al_misalign;
  logic [31:0] al_rd_ext;

  assign idle = (state_q == S_IDLE);

  // In IDLE the aligner sees the live request; afterwards it sees the latched access.
  assign al_size = idle ? size_i : size_q;
  assign al_lo   = idle ? addr_i[1:0] : addr_q[1:0];

  nf_lsu_align u_align (
    .size_i     (al_size),
    .addr_lo_i  (al_lo),
    .sign_ext_i (sign_q),
    .wd_i       (wd_i),
    .rd_i       (rd_dm),
    .wd_rep_o   (al_wd_rep),
    .be_o       (al_be),
    .misalign_o (al_misalign),
    .rd_ext_o   (al_rd_ext)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wd_d       = wd_q;
    be_d       = be_q;
    size_d     = size_q;
    sign_d     = sign_q;
    we_d       = we_q;
    misalign_d = misalign_q;
    rd_data_d  = rd_data_q;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          rd_data_d  = 32'h0;
          misalign_d = al_misalign;
          if (al_misalign) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_i;
            wd_d    = al_wd_rep;
            be_d    = we_i ? al_be : 4'b1111;
            size_d  = size_i;
            sign_d  = sign_ext_i;
            we_d    = we_i;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (ack_dm) begin
          if (we_q) begin
            state_d = S_DONE;
          end else if (rvalid_dm) begin
            rd_data_d = al_rd_ext;
            state_d   = S_DONE;
          end else begin
            state_d = S_WAIT_R;
          end
        end
      end
      S_WAIT_R: begin
        if (rvalid_dm) begin
          rd_data_d = al_rd_ext;
          state_d   = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      addr_q     <= 32'h0;
      wd_q       <= 32'h0;
      be_q       <= 4'h0;
      size_q     <= LSU_BYTE;
      sign_q     <= 1'b0;
      we_q       <= 1'b0;
      misalign_q <= 1'b0;
      rd_data_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wd_q       <= wd_d;
      be_q       <= be_d;
      size_q     <= size_d;
      sign_q     <= sign_d;
      we_q       <= we_d;
      misalign_q <= misalign_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign req_dm     = (state_q == S_REQ);
  assign we_dm      = req_dm & we_q;
  assign be_dm      = req_dm ? be_q : 4'h0;
  assign addr_dm    = {addr_q[31:2], 2'b00};
  assign wd_dm      = wd_q;
  assign done_o     = (state_q == S_DONE);
  assign misalign_o = done_o & misalign_q;
  assign rd_data_o  = rd_data_q;
  assign stall_o    = (idle & req_i) | (state_q == S_REQ) | (state_q == S_WAIT_R);

endmodule

// File: tb/tb_nf_lsu.sv
// Directed bench for nf_lsu: hand-computed expectations checked with immediate assertions.
module tb_nf_lsu;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_i, we_i, sign_ext_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, wd_i;
  logic        stall_o, done_o, misalign_o;
  logic [31:0] rd_data_o, addr_dm, wd_dm;
  logic [3:0]  be_dm;
  logic        we_dm, req_dm;
  logic        ack_dm, rvalid_dm;
  logic [31:0] rd_dm;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nf_lsu dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_i      (req_i),
    .we_i       (we_i),
    .size_i     (size_i),
    .sign_ext_i (sign_ext_i),
    .addr_i     (addr_i),
    .wd_i       (wd_i),
    .stall_o    (stall_o),
    .done_o     (done_o),
    .misalign_o (misalign_o),
    .rd_data_o  (rd_data_o),
    .addr_dm    (addr_dm),
    .wd_dm      (wd_dm),
    .be_dm      (be_dm),
    .we_dm      (we_dm),
    .req_dm     (req_dm),
    .ack_dm     (ack_dm),
    .rvalid_dm  (rvalid_dm),
    .rd_dm      (rd_dm)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are then changed and outputs sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic we, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d);
    req_i = 1'b1; we_i = we; size_i = sz; sign_ext_i = sx; addr_i = a; wd_i = d;
  endtask

  initial begin
    resetn = 1'b0; req_i = 1'b0; we_i = 1'b0; size_i = 2'b00; sign_ext_i = 1'b0;
    addr_i = 32'h0; wd_i = 32'h0; ack_dm = 1'b0; rvalid_dm = 1'b0; rd_dm = 32'h0;
    #2;
    chk("rst_req_dm", {31'h0, req_dm}, 32'h0);
    chk("rst_done", {31'h0, done_o}, 32'h0);
    chk("rst_stall", {31'h0, stall_o}, 32'h0);
    chk("rst_addr_dm", addr_dm, 32'h0);
    chk("rst_wd_dm", wd_dm, 32'h0);
    chk("rst_be_dm", {28'h0, be_dm}, 32'h0);
    chk("rst_rd_data", rd_data_o, 32'h0);
    req_i = 1'b1; settle();
    chk("rst_stall_req", {31'h0, stall_o}, 32'h1);
    req_i = 1'b0;
    tick(); resetn = 1'b1; tick();

    // store byte to 0x103, zero-wait
    issue(1'b1, 2'b00, 1'b0, 32'h103, 32'h0000_00AB); settle();
    chk("sb_c0_stall", {31'h0, stall_o}, 32'h1);
    chk("sb_c0_req_dm", {31'h0, req_dm}, 32'h0);
    tick(); ack_dm = 1'b1; settle();
    chk("sb_c1_req_dm", {31'h0, req_dm}, 32'h1);
    chk("sb_c1_addr", addr_dm, 32'h100);
    chk("sb_c1_wd", wd_dm, 32'hABAB_ABAB);
    chk("sb_c1_be", {28'h0, be_dm}, 32'h8);
    chk("sb_c1_we", {31'h0, we_dm}, 32'h1);
    chk("sb_c1_stall", {31'h0, stall_o}, 32'h1);
    tick(); ack_dm = 1'b0; settle();
    chk("sb_c2_done", {31'h0, done_o}, 32'h1);
    chk("sb_c2_stall", {31'h0, stall_o}, 32'h0);
    chk("sb_c2_misalign", {31'h0, misalign_o}, 32'h0);
    chk("sb_c2_rd_data", rd_data_o, 32'h0);
    chk("sb_c2_req_dm", {31'h0, req_dm}, 32'h0);
    req_i = 1'b0;
    tick();
    chk("sb_c3_done", {31'h0, done_o}, 32'h0);

    // signed half load from 0x202, ack and rvalid together
    issue(1'b0, 2'b01, 1'b1, 32'h202, 32'h0); settle();
    chk("lh_c0_stall", {31'h0, stall_o}, 32'h1);
    tick(); ack_dm = 1'b1; rvalid_dm = 1'b1; rd_dm = 32'h8001_1234; settle();
    chk("lh_c1_stall", {31'h0, stall_o}, 32'h1);
    chk("lh_c1_be", {28'h0, be_dm}, 32'hF);
    chk("lh_c1_we", {31'h0, we_dm}, 32'h0);
    chk("lh_c1_addr", addr_dm, 32'h200);
    tick(); ack_dm = 1'b0; rvalid_dm = 1'b0; rd_dm = 32'h0; settle();
    chk("lh_c2_done", {31'h0, done_o}, 32'h1);
    chk("lh_c2_stall", {31'h0, stall_o}, 32'h0);
    chk("lh_c2_rd_data", rd_data_o, 32'hFFFF_8001);
    req_i = 1'b0;
    tick();

    // unsigned byte load from 0x401: two ack waits, three rvalid waits
    issue(1'b0, 2'b00, 1'b0, 32'h401, 32'h0);
    tick(); settle();
    chk("lb_w1_req_dm", {31'h0, req_dm}, 32'h1);
    chk("lb_w1_addr", addr_dm, 32'h400);
    tick(); rvalid_dm = 1'b1; rd_dm = 32'h1234_5678; settle();
    chk("lb_w2_req_dm", {31'h0, req_dm}, 32'h1);
    chk("lb_w2_addr", addr_dm, 32'h400);
    chk("lb_w2_be", {28'h0, be_dm}, 32'hF);
    tick(); rvalid_dm = 1'b0; rd_dm = 32'h0; ack_dm = 1'b1; settle();
    chk("lb_ack_req_dm", {31'h0, req_dm}, 32'h1);
    chk("lb_ack_addr", addr_dm, 32'h400);
    tick(); ack_dm = 1'b0; settle();
    chk("lb_wr1_req_dm", {31'h0, req_dm}, 32'h0);
    chk("lb_wr1_stall", {31'h0, stall_o}, 32'h1);
    chk("lb_wr1_done", {31'h0, done_o}, 32'h0);
    tick(); settle();
    chk("lb_wr2_stall", {31'h0, stall_o}, 32'h1);
    tick(); rvalid_dm = 1'b1; rd_dm = 32'h0000_F000; settle();
    chk("lb_wr3_stall", {31'h0, stall_o}, 32'h1);
    tick(); rvalid_dm = 1'b0; rd_dm = 32'h0; settle();
    chk("lb_done", {31'h0, done_o}, 32'h1);
    chk("lb_rd_data", rd_data_o, 32'h0000_00F0);
    req_i = 1'b0;
    tick();

    // misaligned word load at 0x6
    issue(1'b0, 2'b10, 1'b0, 32'h6, 32'h0); settle();
    chk("mw_c0_stall", {31'h0, stall_o}, 32'h1);
    chk("mw_c0_req_dm", {31'h0, req_dm}, 32'h0);
    tick();
    chk("mw_c1_done", {31'h0, done_o}, 32'h1);
    chk("mw_c1_misalign", {31'h0, misalign_o}, 32'h1);
    chk("mw_c1_rd_data", rd_data_o, 32'h0);
    chk("mw_c1_stall", {31'h0, stall_o}, 32'h0);
    chk("mw_c1_req_dm", {31'h0, req_dm}, 32'h0);
    req_i = 1'b0;
    tick();
    chk("mw_c2_misalign", {31'h0, misalign_o}, 32'h0);

    // illegal size 11 is rejected even when aligned
    issue(1'b1, 2'b11, 1'b0, 32'h0, 32'h5); tick();
    chk("sz3_done", {31'h0, done_o}, 32'h1);
    chk("sz3_misalign", {31'h0, misalign_o}, 32'h1);
    req_i = 1'b0;
    tick();

    // reset while waiting for read data, then a stray rvalid
    issue(1'b0, 2'b10, 1'b0, 32'h500, 32'h0);
    tick(); ack_dm = 1'b1;
    tick(); ack_dm = 1'b0; settle();
    chk("rw_wait_req_dm", {31'h0, req_dm}, 32'h0);
    chk("rw_wait_stall", {31'h0, stall_o}, 32'h1);
    resetn = 1'b0; req_i = 1'b0; settle();
    chk("rw_rst_stall", {31'h0, stall_o}, 32'h0);
    chk("rw_rst_addr", addr_dm, 32'h0);
    chk("rw_rst_be", {28'h0, be_dm}, 32'h0);
    tick(); resetn = 1'b1; rvalid_dm = 1'b1; rd_dm = 32'hFFFF_FFFF;
    tick(); rvalid_dm = 1'b0; rd_dm = 32'h0; settle();
    chk("rw_late_done", {31'h0, done_o}, 32'h0);
    chk("rw_late_rd_data", rd_data_o, 32'h0);
    chk("rw_late_req_dm", {31'h0, req_dm}, 32'h0);
    chk("rw_late_stall", {31'h0, stall_o}, 32'h0);
    tick();

    // back-to-back: store word 0x300 then load word 0x300
    issue(1'b1, 2'b10, 1'b0, 32'h300, 32'h1122_3344);
    tick(); ack_dm = 1'b1; settle();
    chk("bb_st_wd", wd_dm, 32'h1122_3344);
    chk("bb_st_be", {28'h0, be_dm}, 32'hF);
    tick(); ack_dm = 1'b0; settle();
    chk("bb_st_done", {31'h0, done_o}, 32'h1);
    issue(1'b0, 2'b10, 1'b0, 32'h300, 32'h0); settle();
    chk("bb_done_stall", {31'h0, stall_o}, 32'h0);
    tick();
    chk("bb_idle_stall", {31'h0, stall_o}, 32'h1);
    chk("bb_idle_req_dm", {31'h0, req_dm}, 32'h0);
    tick(); ack_dm = 1'b1; rvalid_dm = 1'b1; rd_dm = 32'hCAFE_BABE; settle();
    chk("bb_ld_req_dm", {31'h0, req_dm}, 32'h1);
    chk("bb_ld_we", {31'h0, we_dm}, 32'h0);
    tick(); ack_dm = 1'b0; rvalid_dm = 1'b0; rd_dm = 32'h0; settle();
    chk("bb_ld_done", {31'h0, done_o}, 32'h1);
    chk("bb_ld_rd_data", rd_data_o, 32'hCAFE_BABE);
    req_i = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
